// File: rtl/controller_pkt_fifo_pkg.sv
// Shared constants and entry layout for the BLAKE2 controller packet FIFO.
package controller_fifo_pkg;

  localparam int BLAKE2B_DBITS    = 64;
  localparam int BLAKE2S_DBITS    = 32;
  localparam int BLAKE2_PKT_WORDS = 16;

  // Stored entry at the BLAKE2b word width: end-of-message flag above the data word.
  typedef struct packed {
    logic                     last;
    logic [BLAKE2B_DBITS-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/controller_pkt_fifo_mem.sv
// Word storage for the packet FIFO: one write port and a PKT_WORDS-wide read window.
module controller_pkt_fifo_mem
  import controller_fifo_pkg::*;
#(
  parameter int DBITS     = BLAKE2B_DBITS,
  parameter int ABITS     = 5,
  parameter int PKT_WORDS = BLAKE2_PKT_WORDS
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [ABITS-1:0]           wr_ptr,
  input  logic [DBITS-1:0]           wr_data,
  input  logic                       wr_last,
  input  logic [ABITS-1:0]           rd_ptr,
  output logic [DBITS*PKT_WORDS-1:0] rd_data,
  output logic [PKT_WORDS-1:0]       rd_last
);

  localparam int DEPTH = 2**ABITS;

  typedef struct packed {
    logic             last;
    logic [DBITS-1:0] data;
  } entry_t;

  // No reset on the array; occupancy alone decides which entries are meaningful.
  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= {wr_last, wr_data};
  end

  always_comb begin
    rd_data = '0;
    rd_last = '0;
    for (int k = 0; k < PKT_WORDS; k++) begin
      rd_data[DBITS*k +: DBITS] = mem_q[rd_ptr + ABITS'(k)].data;
      rd_last[k]                = mem_q[rd_ptr + ABITS'(k)].last;
    end
  end

endmodule

// File: rtl/controller_pkt_fifo.sv
// Word-in, block-out buffer feeding message blocks to the BLAKE2 compression core.
module controller_pkt_fifo
  import controller_fifo_pkg::*;
#(
  parameter int DBITS     = BLAKE2B_DBITS,
  parameter int ABITS     = 5,
  parameter int PKT_WORDS = BLAKE2_PKT_WORDS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DBITS-1:0]             in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DBITS*PKT_WORDS-1:0]   out_data,
  output logic [$clog2(PKT_WORDS+1)-1:0] out_nwords,
  output logic                         out_last,
  output logic [ABITS:0]               count,
  output logic                         empty,
  output logic                         full
);

  localparam int DEPTH = 2**ABITS;
  localparam int NW    = $clog2(PKT_WORDS+1);
  localparam int CW    = ABITS + 1;

  generate
    if (DEPTH < PKT_WORDS) begin : g_depth_chk
      $error("controller_pkt_fifo: DEPTH must be at least PKT_WORDS");
    end
  endgenerate

  logic [ABITS-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DBITS*PKT_WORDS-1:0] out_data_q, out_data_d;
  logic [NW-1:0]              out_nwords_q, out_nwords_d;

  logic [DBITS*PKT_WORDS-1:0] win_data, padded;
  logic [PKT_WORDS-1:0]       win_last;
  logic                       blk_avail, blk_last, wr_ok, load;
  logic [NW-1:0]              blk_n;

  assign in_ready   = (count_q != CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_nwords = out_nwords_q;
  assign out_last   = out_last_q;

  assign wr_ok = !clear && in_valid && in_ready;
  assign load  = !clear && blk_avail && (!out_valid_q || out_ready);

  controller_pkt_fifo_mem #(
    .DBITS(DBITS), .ABITS(ABITS), .PKT_WORDS(PKT_WORDS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_ptr  (wr_ptr_q),
    .wr_data (in_data),
    .wr_last (in_last),
    .rd_ptr  (rd_ptr_q),
    .rd_data (win_data),
    .rd_last (win_last)
  );

  // First end-of-message flag inside the occupied part of the window wins.
  always_comb begin
    blk_avail = 1'b0;
    blk_last  = 1'b0;
    blk_n     = '0;
    for (int k = 0; k < PKT_WORDS; k++) begin
      if (!blk_last && win_last[k] && (count_q > CW'(k))) begin
        blk_last = 1'b1;
        blk_n    = NW'(k + 1);
      end
    end
    if (blk_last) begin
      blk_avail = 1'b1;
    end else if (count_q >= CW'(PKT_WORDS)) begin
      blk_avail = 1'b1;
      blk_n     = NW'(PKT_WORDS);
    end
    padded = '0;
    for (int k = 0; k < PKT_WORDS; k++) begin
      if (NW'(k) < blk_n) padded[DBITS*k +: DBITS] = win_data[DBITS*k +: DBITS];
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_nwords_d = out_nwords_q;
    out_last_d   = out_last_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      out_nwords_d = '0;
      out_last_d   = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ABITS'(1);
      if (load) begin
        rd_ptr_d     = rd_ptr_q + ABITS'(blk_n);
        out_valid_d  = 1'b1;
        out_data_d   = padded;
        out_nwords_d = blk_n;
        out_last_d   = blk_last;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      count_d = count_q + CW'(wr_ok) - (load ? CW'(blk_n) : '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_nwords_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_nwords_q <= out_nwords_d;
      out_last_q   <= out_last_d;
    end
  end

endmodule
